// File: rtl/ipdc_pkg.sv
// Shared opcodes, FSM state encoding and width helpers for the image display controller.
package ipdc_pkg;

    localparam logic [3:0] OP_LOAD     = 4'd0;
    localparam logic [3:0] OP_RIGHT    = 4'd1;
    localparam logic [3:0] OP_LEFT     = 4'd2;
    localparam logic [3:0] OP_UP       = 4'd3;
    localparam logic [3:0] OP_DOWN     = 4'd4;
    localparam logic [3:0] OP_ZOOM_IN  = 4'd5;
    localparam logic [3:0] OP_ZOOM_OUT = 4'd6;
    localparam logic [3:0] OP_GRAY_ON  = 4'd7;
    localparam logic [3:0] OP_GRAY_OFF = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RD,
        ST_DISP
    } ipdc_state_e;

    function automatic int ipdc_coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ipdc_addr_w(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/ipdc_frame_mem.sv
// Frame buffer: flip-flop array with one synchronous write port and one registered read port.
module ipdc_frame_mem #(
    parameter int DEPTH = 64,
    parameter int DW    = 24,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Pixel storage is intentionally left out of reset; a reset must not erase a loaded frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ipdc_window_engine.sv
// Display controller: frame load, movable/resizable window streaming and optional grayscale output.
module ipdc_window_engine
    import ipdc_pkg::*;
#(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int CH_W    = 8,
    parameter int NCH     = 3,
    parameter int WIN_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_op_valid,
    input  logic [3:0]          i_op_mode,
    output logic                o_op_ready,
    input  logic                i_in_valid,
    input  logic [NCH*CH_W-1:0] i_in_data,
    output logic                o_in_ready,
    output logic                o_out_valid,
    output logic [NCH*CH_W-1:0] o_out_data
);

    localparam int XW   = ipdc_coord_w(IMG_W);
    localparam int YW   = ipdc_coord_w(IMG_H);
    localparam int CW   = ipdc_coord_w(WIN_MAX);
    localparam int SZW  = CW + 1;
    localparam int AW   = ipdc_addr_w(IMG_W, IMG_H);
    localparam int DW   = NCH * CH_W;
    localparam int NPIX = IMG_W * IMG_H;

    ipdc_state_e    state;
    logic           op_ready, in_ready, out_valid, gray;
    logic [XW-1:0]  wx, nx, px;
    logic [YW-1:0]  wy, ny, py;
    logic [SZW-1:0] size, nsz;
    logic           ngray;
    logic [CW-1:0]  cx, cy;
    logic           rd_last, row_end, win_end;
    logic [AW-1:0]  ld_cnt, rd_addr;
    logic [DW-1:0]  rd_data, out_px;
    logic [CH_W+1:0] gsum;
    logic [CH_W-1:0] gval;

    ipdc_frame_mem #(
        .DEPTH (NPIX),
        .DW    (DW),
        .AW    (AW)
    ) u_mem (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (in_ready && i_in_valid),
        .wr_addr (ld_cnt),
        .wr_data (i_in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign px      = wx + XW'(cx);
    assign py      = wy + YW'(cy);
    assign rd_addr = (AW'(py) << XW) | AW'(px);
    assign row_end = ({1'b0, cx} == size - SZW'(1));
    assign win_end = row_end && ({1'b0, cy} == size - SZW'(1));

    // Window update for the op being accepted; zoom-out clamps against the already-grown size.
    always_comb begin
        nx    = wx;
        ny    = wy;
        nsz   = size;
        ngray = gray;
        case (i_op_mode)
            OP_RIGHT:    if (32'(wx) + 32'(size) < IMG_W) nx = wx + XW'(1);
            OP_LEFT:     if (wx != '0) nx = wx - XW'(1);
            OP_UP:       if (wy != '0) ny = wy - YW'(1);
            OP_DOWN:     if (32'(wy) + 32'(size) < IMG_H) ny = wy + YW'(1);
            OP_ZOOM_IN:  if (size > SZW'(2)) nsz = size >> 1;
            OP_ZOOM_OUT: begin
                if (32'(size) < WIN_MAX) nsz = size << 1;
                if (32'(wx) > IMG_W - 32'(nsz)) nx = XW'(IMG_W - 32'(nsz));
                if (32'(wy) > IMG_H - 32'(nsz)) ny = YW'(IMG_H - 32'(nsz));
            end
            OP_GRAY_ON:  ngray = 1'b1;
            OP_GRAY_OFF: ngray = 1'b0;
            default:     ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            op_ready  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            wx        <= '0;
            wy        <= '0;
            size      <= SZW'(WIN_MAX);
            gray      <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            rd_last   <= 1'b0;
            ld_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!op_ready) begin
                        op_ready <= 1'b1;
                    end else if (i_op_valid) begin
                        op_ready <= 1'b0;
                        if (i_op_mode == OP_LOAD) begin
                            state    <= ST_LOAD;
                            in_ready <= 1'b1;
                            ld_cnt   <= '0;
                        end else if (i_op_mode <= OP_GRAY_OFF) begin
                            state   <= ST_RD;
                            wx      <= nx;
                            wy      <= ny;
                            size    <= nsz;
                            gray    <= ngray;
                            cx      <= '0;
                            cy      <= '0;
                            rd_last <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (i_in_valid) begin
                        ld_cnt <= ld_cnt + AW'(1);
                        if (ld_cnt == AW'(NPIX - 1)) begin
                            state    <= ST_IDLE;
                            in_ready <= 1'b0;
                            wx       <= '0;
                            wy       <= '0;
                            size     <= SZW'(WIN_MAX);
                            gray     <= 1'b0;
                        end
                    end
                end
                ST_RD, ST_DISP: begin
                    // Reads run one cycle ahead of o_out_valid; rd_last marks the final read already issued.
                    if (state == ST_DISP && rd_last) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        op_ready  <= 1'b1;
                    end else begin
                        state     <= ST_DISP;
                        out_valid <= 1'b1;
                        if (win_end) begin
                            rd_last <= 1'b1;
                        end else if (row_end) begin
                            cx <= '0;
                            cy <= cy + CW'(1);
                        end else begin
                            cx <= cx + CW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gsum   = (CH_W+2)'(rd_data[0 +: CH_W])
               + ((CH_W+2)'(rd_data[CH_W +: CH_W]) << 1)
               + (CH_W+2)'(rd_data[2*CH_W +: CH_W]);
        gval   = gsum[CH_W+1:2];
        out_px = rd_data;
        if (gray) begin
            for (int unsigned k = 0; k < 3; k++) begin
                out_px[k*CH_W +: CH_W] = gval;
            end
        end
    end

    assign o_op_ready  = op_ready;
    assign o_in_ready  = in_ready;
    assign o_out_valid = out_valid;
    assign o_out_data  = out_valid ? out_px : '0;

endmodule

// File: tb/tb_ipdc_window_engine.sv
// Directed bench for ipdc_window_engine on the default 8x8, 3x8-bit, WIN_MAX=4 configuration.
module tb_ipdc_window_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [3:0]  op_mode = 4'd0;
    logic        op_ready;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = 24'd0;
    logic        in_ready;
    logic        out_valid;
    logic [23:0] out_data;

    int checks = 0;
    int failures = 0;
    logic [23:0] frame [64];

    always #5 clk = ~clk;

    ipdc_window_engine #(
        .IMG_W   (8),
        .IMG_H   (8),
        .CH_W    (8),
        .NCH     (3),
        .WIN_MAX (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_op_valid  (op_valid),
        .i_op_mode   (op_mode),
        .o_op_ready  (op_ready),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_px(input int ox, input int oy, input int sz,
                                           input int k, input bit g);
        logic [23:0] p;
        int gv;
        p = frame[(oy + k / sz) * 8 + ox + k % sz];
        if (g) begin
            gv = (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
            p  = {3{8'(gv)}};
        end
        return p;
    endfunction

    // Entered and left just after a falling edge with the engine idle.
    task automatic load_frame(input string tag);
        int idx;
        int cyc;
        bit acc;
        op_valid = 1'b1;
        op_mode  = 4'd0;
        check({tag, "_accept_ready"}, 64'(op_ready), 64'd1);
        @(negedge clk);
        op_valid = 1'b0;
        check({tag, "_in_ready_on"}, 64'(in_ready), 64'd1);
        idx = 0;
        cyc = 0;
        while (idx < 64 && cyc < 300) begin
            in_valid = (cyc % 3 != 2);
            in_data  = frame[idx];
            acc      = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_pix_count"}, 64'(idx), 64'd64);
        check({tag, "_in_ready_off"}, 64'(in_ready), 64'd0);
        check({tag, "_no_out"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_op_ready"}, 64'(op_ready), 64'd1);
        check({tag, "_no_out2"}, 64'(out_valid), 64'd0);
    endtask

    task automatic do_disp(input string tag, input logic [3:0] mode,
                           input int ox, input int oy, input int sz, input bit g);
        op_valid = 1'b1;
        op_mode  = mode;
        check({tag, "_accept_ready"}, 64'(op_ready), 64'd1);
        @(negedge clk);
        op_valid = 1'b0;
        check({tag, "_rd_quiet"}, 64'(out_valid), 64'd0);
        for (int k = 0; k < sz * sz; k++) begin
            @(negedge clk);
            check($sformatf("%s_v%0d", tag, k), 64'(out_valid), 64'd1);
            check($sformatf("%s_px%0d", tag, k), 64'(out_data), 64'(exp_px(ox, oy, sz, k, g)));
        end
        @(negedge clk);
        check({tag, "_end_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_end_ready"}, 64'(op_ready), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) frame[i] = {3{8'(i)}};

        #2;
        check("rst_op_ready", 64'(op_ready), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel_op_ready", 64'(op_ready), 64'd1);

        load_frame("load1");

        do_disp("right1", 4'd1, 1, 0, 4, 1'b0);
        do_disp("right2", 4'd1, 2, 0, 4, 1'b0);
        do_disp("right3", 4'd1, 3, 0, 4, 1'b0);
        do_disp("right4", 4'd1, 4, 0, 4, 1'b0);
        do_disp("right5_clamp", 4'd1, 4, 0, 4, 1'b0);

        do_disp("zin1", 4'd5, 4, 0, 2, 1'b0);
        do_disp("zin2_min", 4'd5, 4, 0, 2, 1'b0);
        do_disp("zout1", 4'd6, 4, 0, 4, 1'b0);
        do_disp("zout2_max", 4'd6, 4, 0, 4, 1'b0);

        frame[0] = 24'h102030;
        load_frame("load2");
        do_disp("gray_on", 4'd7, 0, 0, 4, 1'b1);
        do_disp("gray_off", 4'd8, 0, 0, 4, 1'b0);

        op_valid = 1'b1;
        op_mode  = 4'hF;
        check("ill_accept_ready", 64'(op_ready), 64'd1);
        @(negedge clk);
        op_valid = 1'b0;
        check("ill_busy", 64'(op_ready), 64'd0);
        check("ill_no_out1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("ill_ready_back", 64'(op_ready), 64'd1);
        check("ill_no_out2", 64'(out_valid), 64'd0);

        do_disp("after_ill_right", 4'd1, 1, 0, 4, 1'b0);
        do_disp("down1", 4'd4, 1, 1, 4, 1'b0);
        do_disp("up1", 4'd3, 1, 0, 4, 1'b0);

        op_valid = 1'b1;
        op_mode  = 4'd1;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_valid", 64'(out_valid), 64'd1);
        check("mid_px5", 64'(out_data), 64'(exp_px(2, 0, 4, 4, 1'b0)));
        #1 rst = 1'b1;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_data", 64'(out_data), 64'd0);
        check("async_op_ready", 64'(op_ready), 64'd0);
        @(negedge clk);
        check("hold_op_ready", 64'(op_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel2_op_ready", 64'(op_ready), 64'd1);
        check("rel2_out_valid", 64'(out_valid), 64'd0);

        do_disp("post_rst_left", 4'd2, 0, 0, 4, 1'b0);
        do_disp("post_rst_right", 4'd1, 1, 0, 4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
